// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM/WB stage: FSM states, pipeline bundles and
// the default data-memory base address.
package mem_wb_stage_pkg;

    typedef enum logic {StIdle, StAccess} state_e;

    localparam int unsigned DataBaseDefault = 1024;
    localparam logic [4:0]  RegZero         = 5'd0;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] st_val;
        logic [4:0]  dest;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
    } ex_mem_t;

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  dest;
        logic [31:0] data;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads every cycle, clears to a bubble on request and never
// enables a write to register zero.
module mem_wb_reg
    import mem_wb_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bubble_i,
    input  logic        wb_en_i,
    input  logic [4:0]  dest_i,
    input  logic [31:0] data_i,
    output logic        wb_en_o,
    output logic [4:0]  dest_o,
    output logic [31:0] data_o
);

    mem_wb_t wb_q, wb_d;

    always_comb begin
        wb_d = '0;
        if (!bubble_i) begin
            wb_d.wb_en = wb_en_i & (dest_i != RegZero);
            wb_d.dest  = dest_i;
            wb_d.data  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_en_o = wb_q.wb_en;
    assign dest_o  = wb_q.dest;
    assign data_o  = wb_q.data;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: issues loads/stores to a handshaked data memory, stalls upstream while an
// access is outstanding, aborts after TIMEOUT cycles and drives the register-file write port.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_BASE = DataBaseDefault,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ALU_Result,
    input  logic [31:0]       ST_Val,
    input  logic [4:0]        Dest,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic              WB_EN,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              freeze,
    output logic              WB_Write_Enable,
    output logic [4:0]        WB_Dest,
    output logic [31:0]       WB_Data,
    output logic              mem_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 2);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ex_mem_t         ex_mem;
    logic            mem_op;
    logic            timeout_hit;
    logic            abort;
    logic            latch;
    logic            freeze_raw;
    logic            wb_bubble;
    mem_wb_t         wb_next;
    logic [ADDR_W-1:0] word_addr;

    logic              mem_req_q, mem_we_q, mem_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q, lat_result_q;
    logic [4:0]        lat_dest_q;
    logic              lat_wb_en_q;

    assign ex_mem = '{alu_result: ALU_Result, st_val: ST_Val, dest: Dest,
                      mem_r_en: MEM_R_EN, mem_w_en: MEM_W_EN, wb_en: WB_EN};
    assign mem_op = ex_mem.mem_r_en | ex_mem.mem_w_en;

    // Word offset from the data base; wraps modulo the memory size.
    assign word_addr = ADDR_W'((ex_mem.alu_result - 32'(DATA_BASE)) >> 2);

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));
    assign abort       = (state_q == StAccess) && !mem_ack && timeout_hit;
    assign latch       = (state_q == StIdle) && mem_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (mem_op) state_d = StAccess;
            end
            StAccess: begin
                if (mem_ack || timeout_hit) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        freeze_raw = 1'b0;
        wb_bubble  = 1'b1;
        wb_next    = '0;
        unique case (state_q)
            StIdle: begin
                freeze_raw = mem_op;
                if (!mem_op) begin
                    wb_bubble = 1'b0;
                    wb_next   = '{wb_en: ex_mem.wb_en, dest: ex_mem.dest,
                                  data: ex_mem.alu_result};
                end
            end
            StAccess: begin
                freeze_raw = !mem_ack && !timeout_hit;
                if (mem_ack) begin
                    wb_bubble = 1'b0;
                    wb_next   = '{wb_en: lat_wb_en_q, dest: lat_dest_q,
                                  data: mem_we_q ? lat_result_q : mem_rdata};
                end
            end
            default: ;
        endcase
    end

    assign freeze = rst & freeze_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            lat_result_q <= '0;
            lat_dest_q   <= '0;
            lat_wb_en_q  <= 1'b0;
            mem_err_q    <= 1'b0;
        end else begin
            mem_req_q <= (state_d == StAccess);
            mem_err_q <= mem_err_q | abort;
            if (latch) begin
                // A load with a store flag set still loads; the store is dropped.
                mem_we_q     <= ex_mem.mem_w_en & ~ex_mem.mem_r_en;
                mem_addr_q   <= word_addr;
                mem_wdata_q  <= ex_mem.st_val;
                lat_result_q <= ex_mem.alu_result;
                lat_dest_q   <= ex_mem.dest;
                lat_wb_en_q  <= ex_mem.wb_en;
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_err   = mem_err_q;

    mem_wb_reg u_mem_wb_reg (
        .clk_i    (clk),
        .rst_ni   (rst),
        .bubble_i (wb_bubble),
        .wb_en_i  (wb_next.wb_en),
        .dest_i   (wb_next.dest),
        .data_i   (wb_next.data),
        .wb_en_o  (WB_Write_Enable),
        .dest_o   (WB_Dest),
        .data_o   (WB_Data)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a writeback scoreboard; TIMEOUT is shortened to 4.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ALU_Result;
    logic [31:0] ST_Val;
    logic [4:0]  Dest;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        WB_EN;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        freeze;
    logic        WB_Write_Enable;
    logic [4:0]  WB_Dest;
    logic [31:0] WB_Data;
    logic        mem_err;

    int n_cmp = 0;
    int n_bad = 0;
    int frz;
    logic [36:0] exp_q[$];
    logic [36:0] exp_wb;

    mem_wb_stage #(
        .DATA_BASE (1024),
        .ADDR_W    (8),
        .TIMEOUT   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ALU_Result      (ALU_Result),
        .ST_Val          (ST_Val),
        .Dest            (Dest),
        .MEM_R_EN        (MEM_R_EN),
        .MEM_W_EN        (MEM_W_EN),
        .WB_EN           (WB_EN),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .freeze          (freeze),
        .WB_Write_Enable (WB_Write_Enable),
        .WB_Dest         (WB_Dest),
        .WB_Data         (WB_Data),
        .mem_err         (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] st, input logic [4:0] d,
                         input logic r, input logic w, input logic wb);
        ALU_Result = alu;
        ST_Val     = st;
        Dest       = d;
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        WB_EN      = wb;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one cycle and check any writeback against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (WB_Write_Enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_spurious", {31'b0, WB_Write_Enable}, 32'h0);
            end else begin
                exp_wb = exp_q.pop_front();
                chk("wb_dest", {27'b0, WB_Dest}, {27'b0, exp_wb[36:32]});
                chk("wb_data", WB_Data, exp_wb[31:0]);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        nop();
        MEM_R_EN  = 1'b1;
        #3;
        chk("rst_freeze", {31'b0, freeze}, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_we", {31'b0, mem_we}, 32'h0);
        chk("rst_addr", {24'b0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wben", {31'b0, WB_Write_Enable}, 32'h0);
        chk("rst_wbdest", {27'b0, WB_Dest}, 32'h0);
        chk("rst_wbdata", WB_Data, 32'h0);
        chk("rst_err", {31'b0, mem_err}, 32'h0);
        nop();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU op passes straight through
        drive(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1);
        exp_q.push_back({5'd5, 32'h1234});
        chk("a_freeze", {31'b0, freeze}, 32'h0);
        tick();
        chk("a_wben", {31'b0, WB_Write_Enable}, 32'h1);
        nop();

        // Store acked in first access cycle
        drive(32'd1032, 32'hDEAD, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("b_freeze0", {31'b0, freeze}, 32'h1);
        tick();
        nop();
        chk("b_req", {31'b0, mem_req}, 32'h1);
        chk("b_we", {31'b0, mem_we}, 32'h1);
        chk("b_addr", {24'b0, mem_addr}, 32'd2);
        chk("b_wdata", mem_wdata, 32'hDEAD);
        mem_ack = 1'b1;
        #1;
        chk("b_freeze1", {31'b0, freeze}, 32'h0);
        tick();
        mem_ack = 1'b0;
        chk("b_req_drop", {31'b0, mem_req}, 32'h0);
        chk("b_nowb", {31'b0, WB_Write_Enable}, 32'h0);

        // Load acked in the fourth access cycle
        drive(32'd1028, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
        exp_q.push_back({5'd7, 32'hCAFE});
        #1;
        frz = freeze ? 1 : 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            nop();
            chk("c_req", {31'b0, mem_req}, 32'h1);
            frz += freeze ? 1 : 0;
        end
        chk("c_addr", {24'b0, mem_addr}, 32'd1);
        chk("c_we", {31'b0, mem_we}, 32'h0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE;
        #1;
        frz += freeze ? 1 : 0;
        tick();
        mem_ack = 1'b0;
        chk("c_frz_cycles", 32'(frz), 32'd4);
        chk("c_wben", {31'b0, WB_Write_Enable}, 32'h1);

        // Load with no ack times out
        drive(32'd1040, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            nop();
            chk("d_req", {31'b0, mem_req}, 32'h1);
            chk("d_freeze", {31'b0, freeze}, (i < 4) ? 32'h1 : 32'h0);
        end
        tick();
        chk("d_req_drop", {31'b0, mem_req}, 32'h0);
        chk("d_err", {31'b0, mem_err}, 32'h1);
        chk("d_nowb", {31'b0, WB_Write_Enable}, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("d_stray_ack", {31'b0, mem_req}, 32'h0);
        chk("d_err_sticky", {31'b0, mem_err}, 32'h1);

        // Load+store flags with Dest 0, address below base wraps
        drive(32'd1021, 32'h55, 5'd0, 1'b1, 1'b1, 1'b1);
        tick();
        nop();
        chk("e_we", {31'b0, mem_we}, 32'h0);
        chk("e_addr", {24'b0, mem_addr}, 32'hFF);
        mem_ack   = 1'b1;
        mem_rdata = 32'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk("e_nowb", {31'b0, WB_Write_Enable}, 32'h0);

        // Back-to-back loads
        drive(32'd1032, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
        exp_q.push_back({5'd9, 32'h111});
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h111;
        drive(32'd1036, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1);
        exp_q.push_back({5'd10, 32'h222});
        tick();
        mem_ack = 1'b0;
        chk("f_req_gap", {31'b0, mem_req}, 32'h0);
        chk("f_freeze", {31'b0, freeze}, 32'h1);
        tick();
        nop();
        chk("f_req2", {31'b0, mem_req}, 32'h1);
        chk("f_addr2", {24'b0, mem_addr}, 32'd3);
        mem_ack   = 1'b1;
        mem_rdata = 32'h222;
        tick();
        mem_ack = 1'b0;
        chk("f_wben", {31'b0, WB_Write_Enable}, 32'h1);

        // Reset during an access, then a fresh load
        drive(32'd1024, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1);
        tick();
        nop();
        chk("g_req", {31'b0, mem_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("g_req_rst", {31'b0, mem_req}, 32'h0);
        chk("g_freeze_rst", {31'b0, freeze}, 32'h0);
        chk("g_wben_rst", {31'b0, WB_Write_Enable}, 32'h0);
        chk("g_err_rst", {31'b0, mem_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(32'd1044, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1);
        exp_q.push_back({5'd13, 32'h333});
        tick();
        nop();
        chk("g_addr", {24'b0, mem_addr}, 32'd5);
        mem_ack   = 1'b1;
        mem_rdata = 32'h333;
        tick();
        mem_ack = 1'b0;
        chk("g_wben", {31'b0, WB_Write_Enable}, 32'h1);
        tick();
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
